// File: rtl/udp_pixel_writer_pkg.sv
// udp_pixel_writer_pkg: shared constants, FSM state type and helpers for the pixel writer.
package udp_pixel_writer_pkg;
    localparam int DEF_COL_BITS   = 6;
    localparam int DEF_ROW_BITS   = 6;
    localparam int DEF_PANEL_BITS = 3;
    localparam int DEF_NUM_PANELS = 6;
    localparam logic [7:0] CTRL_PANEL = 8'hFF;
    localparam int BYTES_PER_PIXEL = 3;
    localparam logic [1:0] LAST_PHASE = 2'(BYTES_PER_PIXEL - 1);
    localparam int SWAP_BIT = 0;
    localparam int PIXEL_W = 24;
    typedef enum logic [1:0] {S_IDLE, S_PIXEL, S_CTRL, S_DROP} state_t;
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/udp_pixel_writer_rgb_byte_packer.sv
// udp_pixel_writer_rgb_byte_packer: collects R,G,B bytes into a 24-bit pixel with a done strobe.
module udp_pixel_writer_rgb_byte_packer
    import udp_pixel_writer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               feed_i,
    input  logic [7:0]         byte_i,
    output logic [1:0]         phase_o,
    output logic               done_o,
    output logic [PIXEL_W-1:0] pixel_o
);
    logic [1:0] phase_q;
    logic [7:0] r_q, g_q;

    assign phase_o = phase_q;
    assign done_o  = feed_i & (phase_q == LAST_PHASE);
    assign pixel_o = {r_q, g_q, byte_i};

    // start_i forces a fresh pixel: the byte is R regardless of leftover phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
            r_q     <= '0;
            g_q     <= '0;
        end else if (start_i) begin
            phase_q <= 2'd1;
            r_q     <= byte_i;
        end else if (feed_i) begin
            phase_q <= (phase_q == LAST_PHASE) ? 2'd0 : phase_q + 2'd1;
            if (phase_q == 2'd0) r_q <= byte_i;
            if (phase_q == 2'd1) g_q <= byte_i;
        end
    end
endmodule

// File: rtl/udp_pixel_writer.sv
// udp_pixel_writer: decodes UDP port into panel/row, packs RGB payload into framebuffer writes,
// handles frame-swap control packets and counts malformed packets.
module udp_pixel_writer
    import udp_pixel_writer_pkg::*;
#(
    parameter int COL_BITS   = DEF_COL_BITS,
    parameter int ROW_BITS   = DEF_ROW_BITS,
    parameter int PANEL_BITS = DEF_PANEL_BITS,
    parameter int NUM_PANELS = DEF_NUM_PANELS
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic                                 in_last,
    input  logic [15:0]                          in_dst_port,
    input  logic [15:0]                          in_length,
    input  logic [7:0]                           in_data,
    output logic                                 fb_we,
    input  logic                                 fb_ready,
    output logic [PANEL_BITS+ROW_BITS+COL_BITS-1:0] fb_addr,
    output logic [PIXEL_W-1:0]                   fb_wdata,
    output logic                                 frame_swap,
    output logic [15:0]                          err_count
);
    state_t                  state_q;
    logic [PANEL_BITS-1:0]   panel_q;
    logic [ROW_BITS-1:0]     row_q;
    logic [COL_BITS:0]       col_q, col_nxt;
    logic                    pkt_err_q;
    logic                    acc, idle, is_ctrl, is_pix, start, feed, done, partial, err_now, bad_pkt;
    logic [1:0]              phase;
    logic [PIXEL_W-1:0]      pixel;
    state_t                  state_nxt;
    logic                    unused_len;

    assign unused_len = ^in_length;
    assign in_ready   = !(fb_we & !fb_ready);
    assign acc        = in_valid & in_ready;
    assign idle       = state_q == S_IDLE;
    assign is_ctrl    = in_dst_port[15:8] == CTRL_PANEL;
    assign is_pix     = (in_dst_port[15:8] < 8'(NUM_PANELS)) && ({1'b0, in_dst_port[7:0]} < 9'(2**ROW_BITS));
    assign start      = acc & idle & is_pix;
    // once the row is full (top col bit set) further payload bytes are not packed
    assign feed       = acc & (state_q == S_PIXEL) & !col_q[COL_BITS];
    assign col_nxt    = done ? col_q + 1'b1 : col_q;
    assign partial    = start | (feed ? phase != LAST_PHASE : phase != 2'd0);
    assign err_now    = acc & ((idle & !is_ctrl & !is_pix)
                             | ((state_q == S_PIXEL) & col_q[COL_BITS])
                             | ((start | (state_q == S_PIXEL)) & in_last & (partial | !col_nxt[COL_BITS])));
    assign bad_pkt    = pkt_err_q | err_now;
    assign state_nxt  = idle ? (is_ctrl ? S_CTRL : is_pix ? S_PIXEL : S_DROP) : state_q;

    udp_pixel_writer_rgb_byte_packer u_packer (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .feed_i  (feed),
        .byte_i  (in_data),
        .phase_o (phase),
        .done_o  (done),
        .pixel_o (pixel)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            panel_q    <= '0;
            row_q      <= '0;
            col_q      <= '0;
            pkt_err_q  <= 1'b0;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_wdata   <= '0;
            frame_swap <= 1'b0;
            err_count  <= '0;
        end else begin
            if (acc) state_q <= in_last ? S_IDLE : state_nxt;
            if (acc) pkt_err_q <= in_last ? 1'b0 : bad_pkt;
            if (acc && in_last && bad_pkt) err_count <= sat_inc(err_count);
            if (start) begin
                panel_q <= in_dst_port[8 +: PANEL_BITS];
                row_q   <= in_dst_port[0 +: ROW_BITS];
            end
            col_q      <= start ? '0 : col_nxt;
            frame_swap <= acc & idle & is_ctrl & in_data[SWAP_BIT];
            // a completing pixel can only arrive when the holding register is free
            if (done) begin
                fb_we    <= 1'b1;
                fb_addr  <= {panel_q, row_q, col_q[COL_BITS-1:0]};
                fb_wdata <= pixel;
            end else if (fb_ready) begin
                fb_we <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_udp_pixel_writer.sv
// tb_udp_pixel_writer: directed packets with hand-computed write addresses, data and error counts.
module tb_udp_pixel_writer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, in_last = 1'b0, fb_ready = 1'b1;
    logic        in_ready, fb_we, frame_swap;
    logic [15:0] in_dst_port = '0, in_length = '0, err_count;
    logic [7:0]  in_data = '0;
    logic [14:0] fb_addr;
    logic [23:0] fb_wdata;
    int          total = 0, bad = 0, wr_n = 0, swaps = 0, stalls = 0, cyc = 0;
    bit          slow = 1'b0;
    logic [2:0]  exp_panel = '0;
    logic [5:0]  exp_row = '0;

    always #5 clk = ~clk;

    udp_pixel_writer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_dst_port(in_dst_port), .in_length(in_length), .in_data(in_data), .fb_we(fb_we),
        .fb_ready(fb_ready), .fb_addr(fb_addr), .fb_wdata(fb_wdata), .frame_swap(frame_swap),
        .err_count(err_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // one clock: drive fb_ready, sample outputs mid-cycle, record handshakes
    task automatic tick(output bit acc);
        int k;
        fb_ready = slow ? (cyc % 3 == 0) : 1'b1;
        cyc++;
        #1;
        chk("in_ready_rule", 32'(in_ready), 32'(!(fb_we && !fb_ready)));
        if (frame_swap) swaps++;
        if (fb_we && !fb_ready) stalls++;
        if (fb_we && fb_ready) begin
            k = wr_n;
            chk("fb_addr", 32'(fb_addr), 32'({exp_panel, exp_row, 6'(k)}));
            chk("fb_wdata", 32'(fb_wdata), 32'({8'(3 * k), 8'(3 * k + 1), 8'(3 * k + 2)}));
            wr_n++;
        end
        acc = in_valid && in_ready;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        bit a;
        repeat (n) tick(a);
    endtask

    task automatic send(input logic [15:0] port, input int n, input bit with_last, input logic [7:0] base);
        bit acc;
        int guard;
        in_dst_port = port;
        in_length   = 16'(n);
        wr_n        = 0;
        exp_panel   = port[10:8];
        exp_row     = port[5:0];
        for (int j = 0; j < n; j++) begin
            in_valid = 1'b1;
            in_data  = base + 8'(j);
            in_last  = with_last && (j == n - 1);
            acc      = 1'b0;
            guard    = 0;
            while (!acc && guard < 50) begin
                tick(acc);
                guard++;
            end
            if (!acc) begin
                chk("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_fb_we", 32'(fb_we), 32'd0);
        chk("rst_fb_addr", 32'(fb_addr), 32'd0);
        chk("rst_fb_wdata", 32'(fb_wdata), 32'd0);
        chk("rst_swap", 32'(frame_swap), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        send(16'h0203, 192, 1'b1, 8'h00);
        drain(8);
        chk("fast_writes", 32'(wr_n), 32'd64);
        chk("fast_err", 32'(err_count), 32'd0);

        slow   = 1'b1;
        stalls = 0;
        send(16'h0203, 192, 1'b1, 8'h00);
        drain(12);
        slow = 1'b0;
        chk("slow_writes", 32'(wr_n), 32'd64);
        chk("slow_stall_seen", 32'(stalls > 0), 32'd1);
        chk("slow_err", 32'(err_count), 32'd0);

        send(16'h0600, 10, 1'b1, 8'h00);
        drain(4);
        chk("bad_panel_writes", 32'(wr_n), 32'd0);
        chk("bad_panel_err", 32'(err_count), 32'd1);

        send(16'h0203, 192, 1'b1, 8'h00);
        drain(8);
        chk("after_drop_writes", 32'(wr_n), 32'd64);
        chk("after_drop_err", 32'(err_count), 32'd1);

        swaps = 0;
        send(16'hFF00, 1, 1'b1, 8'h01);
        chk("swap_now", 32'(frame_swap), 32'd1);
        drain(3);
        chk("swap_once", 32'(swaps), 32'd1);
        swaps = 0;
        send(16'hFF00, 1, 1'b1, 8'h00);
        drain(3);
        chk("swap_none", 32'(swaps), 32'd0);
        swaps = 0;
        send(16'hFF00, 3, 1'b1, 8'h01);
        drain(3);
        chk("swap_first_only", 32'(swaps), 32'd1);
        chk("ctrl_err", 32'(err_count), 32'd1);

        send(16'h0203, 100, 1'b1, 8'h00);
        drain(8);
        chk("short_writes", 32'(wr_n), 32'd33);
        chk("short_err", 32'(err_count), 32'd2);

        send(16'h0203, 200, 1'b1, 8'h00);
        drain(8);
        chk("long_writes", 32'(wr_n), 32'd64);
        chk("long_err", 32'(err_count), 32'd3);

        send(16'h0140, 3, 1'b1, 8'h00);
        drain(4);
        chk("bad_row_writes", 32'(wr_n), 32'd0);
        chk("bad_row_err", 32'(err_count), 32'd4);

        send(16'h0105, 50, 1'b0, 8'h00);
        chk("pre_rst_writes", 32'(wr_n), 32'd16);
        rst = 1'b1;
        #1;
        chk("mid_rst_fb_we", 32'(fb_we), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_err", 32'(err_count), 32'd0);
        chk("mid_rst_addr", 32'(fb_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        swaps = 0;
        send(16'h0105, 192, 1'b1, 8'h00);
        drain(8);
        chk("post_rst_writes", 32'(wr_n), 32'd64);
        chk("post_rst_err", 32'(err_count), 32'd0);
        chk("post_rst_swaps", 32'(swaps), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
